// File: rtl/nios_system_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package nios_system_sysid_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_ID = 3'd1,
    S_RD_TS = 3'd2,
    S_CMP   = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;
  localparam int   CNT_W   = 16;

endpackage

// File: rtl/nios_system_sysid_wait_ctr.sv
// Consecutive-waitrequest counter; hit asserts once the count reaches LIMIT.
module nios_system_sysid_wait_ctr
  import nios_system_sysid_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign hit = (cnt_q == CNT_W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)             cnt_d = '0;
    else if (inc && !hit) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nios_system_sysid_checker.sv
// Reads the sysid ID/timestamp words over Avalon-MM and compares them to parameters.
// Optional read timeout enabled by defining SYSID_CHECKER_TIMEOUT_EN.
module nios_system_sysid_checker
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  state_e      state_q;
  logic        read_q, addr_q, busy_q, done_q, pass_q;
  logic [31:0] id_q, ts_q;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  logic timeout_q;
  logic hit;

  // Counter clears in every non-read cycle, so each read starts from zero.
  nios_system_sysid_wait_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_wait_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (!read_q),
    .inc     (read_q && avm_waitrequest),
    .hit     (hit)
  );

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      read_q    <= 1'b0;
      addr_q    <= ADDR_ID;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      id_q      <= '0;
      ts_q      <= '0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q   <= S_RD_ID;
          read_q    <= 1'b1;
          addr_q    <= ADDR_ID;
          busy_q    <= 1'b1;
          pass_q    <= 1'b0;
          id_q      <= '0;
          ts_q      <= '0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
        end
        S_RD_ID: if (!avm_waitrequest) begin
          id_q    <= avm_readdata;
          read_q  <= 1'b0;
          addr_q  <= ADDR_TS;
          state_q <= S_RD_TS;
`ifdef SYSID_CHECKER_TIMEOUT_EN
        end else if (hit) begin
          read_q    <= 1'b0;
          timeout_q <= 1'b1;
          pass_q    <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= S_FIN;
`endif
        end
        // First RD_TS cycle is the mandatory read-idle gap.
        S_RD_TS: if (!read_q) begin
          read_q <= 1'b1;
        end else if (!avm_waitrequest) begin
          ts_q    <= avm_readdata;
          read_q  <= 1'b0;
          state_q <= S_CMP;
`ifdef SYSID_CHECKER_TIMEOUT_EN
        end else if (hit) begin
          read_q    <= 1'b0;
          timeout_q <= 1'b1;
          pass_q    <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= S_FIN;
`endif
        end
        S_CMP: begin
          pass_q  <= (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
          done_q  <= 1'b1;
          state_q <= S_FIN;
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          read_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/nios_system_sysid_checker.md
NIOS_SYSTEM_SYSID_CHECKER -- requirements
Module: nios_system_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000: system ID value expected at slave address 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'h0000_0000: timestamp value expected at slave address 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum waitrequest cycles tolerated per read, range 1..65535.
REQ-004 SHALL have port clock, input, 1: single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins a check.
REQ-007 SHALL have port avm_address, output, 1: 0 selects the ID word, 1 selects the timestamp word.
REQ-008 SHALL have port avm_read, output, 1: read request.
REQ-009 SHALL have port avm_waitrequest, input, 1: slave stall.
REQ-010 SHALL have port avm_readdata, input, 32: slave read data.
REQ-011 SHALL have port busy, output, 1: check in progress.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when a check ends.
REQ-013 SHALL have port pass, output, 1: last check matched both words; held until next start.
REQ-014 SHALL have port timeout, output, 1: last check aborted on timeout; held until next start.
REQ-015 SHALL have ports id_value and ts_value, output, 32 each: captured words from the last check.

Function
REQ-016 SHALL implement FSM states IDLE, RD_ID, RD_TS, CMP, FIN.
REQ-017 IDLE SHALL go to RD_ID on start; start outside IDLE SHALL be ignored.
REQ-018 RD_ID SHALL assert avm_read=1 and avm_address=0, holding both stable while avm_waitrequest=1.
REQ-019 A read SHALL complete in the cycle where avm_read=1 and avm_waitrequest=0; avm_readdata is captured that cycle (zero-latency, non-pipelined).
REQ-020 RD_ID completion SHALL capture id_value and go to RD_TS; RD_TS (address 1) completion SHALL capture ts_value and go to CMP.
REQ-021 avm_read SHALL deassert for at least one cycle between the two reads (RD_ID to RD_TS passes through one idle cycle with avm_read=0).
REQ-022 CMP SHALL set pass = (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TS) using a full 32-bit compare, then go to FIN.
REQ-023 FIN SHALL pulse done for exactly one cycle and return to IDLE; total latency with zero waitrequest is 5 cycles from start to done.
REQ-024 busy SHALL be 1 in RD_ID, RD_TS, CMP, and FIN, and 0 in IDLE.
REQ-025 start in IDLE SHALL clear pass, timeout, id_value, and ts_value on the same edge as the transition.

Reset
REQ-026 reset_n=0 at an edge SHALL force IDLE, avm_read=0, avm_address=0, busy=0, done=0, pass=0, timeout=0, id_value=0, ts_value=0, and wait counter=0.
REQ-027 reset mid-read SHALL drop avm_read on that edge; no done pulse SHALL follow.

Configuration
REQ-028 With SYSID_CHECKER_TIMEOUT_EN defined, a per-read 16-bit counter SHALL count consecutive waitrequest cycles and reset at the start of each read.
REQ-029 With SYSID_CHECKER_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES the FSM SHALL drop avm_read, set timeout=1 and pass=0, and go to FIN.
REQ-030 Without SYSID_CHECKER_TIMEOUT_EN, the counter SHALL be absent, timeout SHALL be tied to 0, and reads SHALL wait indefinitely.

Structure
REQ-031 The state enum, the address constants (ADDR_ID=0, ADDR_TS=1), and the counter width SHALL live in package nios_system_sysid_pkg.
REQ-032 The timeout counter SHALL be sub-module nios_system_sysid_wait_ctr (inputs clr and inc; output hit); the FSM stays in the top module.

Verification
REQ-033 Zero-wait slave, ID=0, TS=32'h5817_A5E4, EXPECTED matching, start pulse: done 5 cycles later, pass=1, ts_value=32'h5817_A5E4.
REQ-034 Slave returns TS=32'h5817_A5E5 while EXPECTED_TS=32'h5817_A5E4: pass=0, done=1, timeout=0.
REQ-035 Waitrequest held 3 cycles on each read: avm_address and avm_read stable throughout; done at cycle 11; pass=1.
REQ-036 Macro defined, TIMEOUT_CYCLES=4, waitrequest stuck at 1: timeout=1, pass=0, done pulses; avm_read=0 afterwards.
REQ-037 reset_n=0 during RD_TS then released, followed by a second start: all outputs are 0 after the reset edge, and the second check passes normally.
REQ-038 start pulsed while busy: ignored, with a single done pulse and captured values unaffected.
